ingress_sched: RTL

INGRESS_SCHED -- requirements
Module: ingress_sched

---
 rtl/mure_pkg.sv | 36 +++
 rtl/te_bundle_fifo.sv | 69 ++++++
 rtl/ingress_sched.sv | 88 ++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared trace-encoder types: retirement lane entry and the bundle of lanes
// retired in one cycle.
package mure_pkg;

  localparam int unsigned NrRetiredInstr = 4;

  typedef enum logic [2:0] {
    NOP,
    STD,
    EXC,
    INTR,
    BR_T,
    BR_NT,
    JUMP
  } itype_e;

  typedef struct packed {
    itype_e      itype;
    logic [1:0]  ilen;
    logic [31:0] pc;
  } uop_entry_s;

  // ivalids[NrRetiredInstr-1] qualifies lane A, bit 0 qualifies lane D.
  typedef struct packed {
    logic [NrRetiredInstr-1:0] ivalids;
    uop_entry_s                uop_a;
    uop_entry_s                uop_b;
    uop_entry_s                uop_c;
    uop_entry_s                uop_d;
  } bundle_s;

  function automatic logic bundle_has_data(input bundle_s b);
    return |b.ivalids;
  endfunction

endpackage

// File: rtl/te_bundle_fifo.sv
// Circular buffer of retirement bundles with registered pointers and an
// occupancy counter; head output is forced to zero while empty.
module te_bundle_fifo
  import mure_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  bundle_s                  data_i,
  output bundle_s                  data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  bundle_s         mem_q [Depth];
  logic            pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Depth is a power of two, so the pointer increment wraps Depth-1 -> 0.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/ingress_sched.sv
// Trace ingress buffer: queues retirement bundles for the ingress FSM and
// accounts for bundles discarded while the queue is full.
module ingress_sched
  import mure_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [NrRetiredInstr-1:0] ivalids_i,
  input  uop_entry_s                uop_a_i,
  input  uop_entry_s                uop_b_i,
  input  uop_entry_s                uop_c_i,
  input  uop_entry_s                uop_d_i,
  input  logic                      pop_i,
  output logic                      valid_o,
  output logic [NrRetiredInstr-1:0] ivalids_o,
  output uop_entry_s                uop_a_o,
  output uop_entry_s                uop_b_o,
  output uop_entry_s                uop_c_o,
  output uop_entry_s                uop_d_o,
  output logic [$clog2(Depth):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic [15:0]               drop_cnt_o
);

  bundle_s     in_bundle, head;
  logic        has_data, pop_ok, push, drop;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign in_bundle = '{ivalids: ivalids_i, uop_a: uop_a_i, uop_b: uop_b_i,
                       uop_c: uop_c_i, uop_d: uop_d_i};
  assign has_data  = bundle_has_data(in_bundle);
  assign pop_ok    = en_i & pop_i & ~empty_o;
  assign push      = en_i & has_data & (~full_o | pop_ok);
  assign drop      = en_i & has_data & full_o & ~pop_ok;

  te_bundle_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (~en_i),
    .push_i  (push),
    .pop_i   (pop_ok),
    .data_i  (in_bundle),
    .data_o  (head),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign valid_o   = ~empty_o;
  assign ivalids_o = head.ivalids;
  assign uop_a_o   = head.uop_a;
  assign uop_b_o   = head.uop_b;
  assign uop_c_o   = head.uop_c;
  assign uop_d_o   = head.uop_d;

  // Clear is applied first so a coincident drop still registers as one.
  always_comb begin
    overflow_d = clr_i ? 1'b0 : overflow_q;
    drop_cnt_d = clr_i ? '0 : drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
